spart_echo_driver: RTL and testbench

//  Synthesizable host-side bus master for the SPART register interface.
//  - After reset, programs the baud divisor selected by br_cfg.
//  - Then runs a receive->transmit echo loop through an internal DEPTH-entry byte FIFO.
//  - Reprograms the divisor on the fly whenever br_cfg changes.
//  - Sits between board switches/LEDs and the SPART databus.

---
 rtl/spart_echo_driver_if.sv | 35 +++
 rtl/spart_echo_driver.sv | 231 +++++++++++++++++++++++
 tb/tb_spart_echo_driver.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/spart_echo_driver_if.sv
// spart_echo_driver_if
//   Control/handshake side of the SPART register bus.
//   master : the host-side driver (spart_echo_driver)
//   slave  : the SPART itself (or a model of it)
//   Signals:
//     rda    SPART -> host   receive data available
//     tbr    SPART -> host   transmit buffer ready
//     iocs   host  -> SPART  chip select, one cycle per access
//     iorw   host  -> SPART  1 = read, 0 = write
//     ioaddr host  -> SPART  00 TX/RX buffer, 01 status, 10 div low, 11 div high
//   The 8-bit databus is bidirectional and is carried as a separate inout
//   port on the driver so that its tristate resolution stays at module level.
interface spart_echo_driver_if;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;

    modport master (
        input  rda,
        input  tbr,
        output iocs,
        output iorw,
        output ioaddr
    );

    modport slave (
        output rda,
        output tbr,
        input  iocs,
        input  iorw,
        input  ioaddr
    );
endinterface

// File: rtl/spart_echo_driver.sv
// spart_echo_driver
//   Host-side bus master for the SPART register interface. Programs the
//   baud divisor chosen by br_cfg after reset and whenever br_cfg changes,
//   and otherwise echoes received bytes back out through a DEPTH-entry FIFO.
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous reset, active low
//     br_cfg     baud select 0..3 (asynchronous, synchronised here)
//     enable     1 = echo loop runs; divisor programming ignores it
//     bus        SPART control signals (rda/tbr in, iocs/iorw/ioaddr out)
//     databus    SPART data, driven only during write cycles
//     fifo_level echo FIFO occupancy, DEPTH means full
//     rx_cnt     bytes read from the SPART, wrapping
//     tx_cnt     bytes written to the SPART, wrapping
//     cfg_busy   high while a divisor write sequence is in progress
//   GUARD must be at least 2.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   DIV_LO  | write divisor low byte (ioaddr 10)
//   DIV_HI  | write divisor high byte (ioaddr 11), commit applied cfg
//   GUARD_W | quiet cycles after an access
//   IDLE    | sample cfg change / rda / tbr and pick the next access
//   RD_RX   | read RX buffer (ioaddr 00), push byte into the FIFO
//   WR_TX   | write FIFO head to TX buffer (ioaddr 00), pop
module spart_echo_driver #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD0  = 4800,
    parameter int BAUD1  = 9600,
    parameter int BAUD2  = 19200,
    parameter int BAUD3  = 38400,
    parameter int DEPTH  = 8,
    parameter int GUARD  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              br_cfg,
    input  logic                    enable,
    spart_echo_driver_if.master     bus,
    inout  wire  [7:0]              databus,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [CNT_W-1:0]        rx_cnt,
    output logic [CNT_W-1:0]        tx_cnt,
    output logic                    cfg_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GUARD > 2) ? $clog2(GUARD) : 1;

    localparam logic [15:0] DIV0 = 16'(CLK_HZ / (16 * BAUD0) - 1);
    localparam logic [15:0] DIV1 = 16'(CLK_HZ / (16 * BAUD1) - 1);
    localparam logic [15:0] DIV2 = 16'(CLK_HZ / (16 * BAUD2) - 1);
    localparam logic [15:0] DIV3 = 16'(CLK_HZ / (16 * BAUD3) - 1);

    // The access cycle is followed by GUARD non-access cycles: GUARD-1 in
    // GUARD_W and the IDLE cycle in which rda/tbr are sampled again.
    localparam logic [GW-1:0] GUARD_LD = GW'(GUARD - 2);

    typedef enum logic [2:0] {
        DIV_LO,
        DIV_HI,
        GUARD_W,
        IDLE,
        RD_RX,
        WR_TX
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic            run_q;
    logic [GW-1:0]   guard_cnt;

    logic [1:0]      cfg_s1;
    logic [1:0]      cfg_s2;
    logic [1:0]      cfg_tgt;
    logic [1:0]      cfg_app;
    logic            cfg_pend;
    logic [15:0]     div_val;

    logic [7:0]      fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            fifo_full;
    logic            fifo_empty;

    logic            iocs_c;
    logic            iorw_c;
    logic [1:0]      ioaddr_c;
    logic            drive_c;
    logic [7:0]      dout_c;

    assign cfg_pend   = (cfg_s2 != cfg_app);
    assign fifo_full  = (fifo_level == LW'(DEPTH));
    assign fifo_empty = (fifo_level == '0);

    always_comb begin
        div_val = DIV0;
        case (cfg_tgt)
            2'd1:    div_val = DIV1;
            2'd2:    div_val = DIV2;
            2'd3:    div_val = DIV3;
            default: div_val = DIV0;
        endcase
    end

    // run_q is low while rst is asserted and for the first clock after its
    // release, so bus outputs show their idle values during reset and drop
    // asynchronously when reset hits mid-access.
    always_comb begin
        state_nx = state;
        iocs_c   = 1'b0;
        iorw_c   = 1'b1;
        ioaddr_c = 2'b00;
        drive_c  = 1'b0;
        dout_c   = 8'h00;
        case (state)
            DIV_LO: begin
                if (run_q) begin
                    state_nx = DIV_HI;
                    iocs_c   = 1'b1;
                    iorw_c   = 1'b0;
                    ioaddr_c = 2'b10;
                    drive_c  = 1'b1;
                    dout_c   = div_val[7:0];
                end
            end
            DIV_HI: begin
                state_nx = GUARD_W;
                iocs_c   = 1'b1;
                iorw_c   = 1'b0;
                ioaddr_c = 2'b11;
                drive_c  = 1'b1;
                dout_c   = div_val[15:8];
            end
            GUARD_W: begin
                if (guard_cnt == '0) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                if (cfg_pend) begin
                    state_nx = DIV_LO;
                end else if (enable && bus.rda && !fifo_full) begin
                    state_nx = RD_RX;
                end else if (enable && bus.tbr && !fifo_empty) begin
                    state_nx = WR_TX;
                end
            end
            RD_RX: begin
                state_nx = GUARD_W;
                iocs_c   = 1'b1;
            end
            WR_TX: begin
                state_nx = GUARD_W;
                iocs_c   = 1'b1;
                iorw_c   = 1'b0;
                drive_c  = 1'b1;
                dout_c   = fifo_mem[rd_ptr];
            end
            default: state_nx = DIV_LO;
        endcase
    end

    assign bus.iocs   = iocs_c;
    assign bus.iorw   = iorw_c;
    assign bus.ioaddr = ioaddr_c;
    assign databus    = drive_c ? dout_c : 8'hzz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= DIV_LO;
            run_q      <= 1'b0;
            guard_cnt  <= '0;
            cfg_busy   <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rx_cnt     <= '0;
            tx_cnt     <= '0;
        end else begin
            run_q <= 1'b1;
            state <= state_nx;

            if (state == DIV_HI || state == RD_RX || state == WR_TX) begin
                guard_cnt <= GUARD_LD;
            end else if (state == GUARD_W && guard_cnt != '0) begin
                guard_cnt <= guard_cnt - GW'(1);
            end

            if (state == IDLE && cfg_pend) begin
                cfg_busy <= 1'b1;
            end else if (state == GUARD_W && state_nx == IDLE) begin
                cfg_busy <= 1'b0;
            end

            if (state == RD_RX) begin
                wr_ptr     <= wr_ptr + AW'(1);
                fifo_level <= fifo_level + LW'(1);
                rx_cnt     <= rx_cnt + CNT_W'(1);
            end else if (state == WR_TX) begin
                rd_ptr     <= rd_ptr + AW'(1);
                fifo_level <= fifo_level - LW'(1);
                tx_cnt     <= tx_cnt + CNT_W'(1);
            end
        end
    end

    // br_cfg synchroniser and cfg tracking keep clocking during reset, so
    // the divisor written first after reset matches the switches directly.
    // cfg_tgt is frozen for the whole DIV_LO/DIV_HI pair so both halves
    // always come from the same divisor.
    always_ff @(posedge clk) begin
        cfg_s1 <= br_cfg;
        cfg_s2 <= cfg_s1;
        if (!run_q || (state == IDLE && cfg_pend)) begin
            cfg_tgt <= cfg_s2;
        end
        if (!run_q) begin
            cfg_app <= cfg_s2;
        end else if (state == DIV_HI) begin
            cfg_app <= cfg_tgt;
        end
        if (state == RD_RX) begin
            fifo_mem[wr_ptr] <= databus;
        end
    end

endmodule

// File: tb/tb_spart_echo_driver.sv
// tb_spart_echo_driver
//   Directed bench for spart_echo_driver with a small SPART model: an RX
//   byte queue that raises rda, a tbr control, and a log of every bus access
//   observed on the falling clock edge.
module tb_spart_echo_driver;
    localparam int DEPTH = 8;
    localparam int GUARD = 2;
    localparam int CNT_W = 16;

    logic                   clk    = 1'b0;
    logic                   rst    = 1'b0;
    logic [1:0]             br_cfg = 2'b01;
    logic                   enable = 1'b0;
    wire  [7:0]             databus;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0]       rx_cnt;
    logic [CNT_W-1:0]       tx_cnt;
    logic                   cfg_busy;

    spart_echo_driver_if sif ();

    spart_echo_driver #(
        .DEPTH (DEPTH),
        .GUARD (GUARD),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .enable     (enable),
        .bus        (sif),
        .databus    (databus),
        .fifo_level (fifo_level),
        .rx_cnt     (rx_cnt),
        .tx_cnt     (tx_cnt),
        .cfg_busy   (cfg_busy)
    );

    always #5 clk = ~clk;

    // SPART model state
    logic [7:0] rx_q [$];
    logic [9:0] wr_log [$];
    logic [7:0] tx_log [$];
    bit         acc_seq [$];
    logic [7:0] spart_rx_byte = 8'h00;
    bit         pop_next = 1'b0;
    int         cyc = 0;
    int         last_cs = -1000;
    int         min_gap = 1000;
    int         rd_count = 0;
    int         last_rd_cyc = 0;
    int         last_tx_cyc = 0;

    int         n_chk = 0;
    int         n_pass = 0;
    bit         found;

    assign databus = (sif.iocs && sif.iorw && sif.ioaddr == 2'b00) ? spart_rx_byte : 8'hzz;

    always @(negedge clk) begin
        cyc++;
        if (pop_next) begin
            void'(rx_q.pop_front());
            pop_next = 1'b0;
        end
        if (sif.iocs) begin
            if (cyc - last_cs < min_gap) min_gap = cyc - last_cs;
            last_cs = cyc;
            if (sif.iorw) begin
                if (sif.ioaddr == 2'b00) begin
                    rd_count++;
                    pop_next    = 1'b1;
                    last_rd_cyc = cyc;
                    acc_seq.push_back(1'b1);
                end
            end else begin
                wr_log.push_back({sif.ioaddr, databus});
                if (sif.ioaddr == 2'b00) begin
                    tx_log.push_back(databus);
                    last_tx_cyc = cyc;
                    acc_seq.push_back(1'b0);
                end
            end
        end
        sif.rda       = (rx_q.size() != 0);
        spart_rx_byte = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    initial begin
        sif.tbr = 1'b0;

        // Reset with br_cfg = 01
        repeat (5) @(negedge clk);
        check("rst_iocs", 32'(sif.iocs), 32'd0);
        check("rst_iorw", 32'(sif.iorw), 32'd1);
        check("rst_ioaddr", 32'(sif.ioaddr), 32'd0);
        check("rst_cfg_busy", 32'(cfg_busy), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_rx_cnt", 32'(rx_cnt), 32'd0);
        wr_log.delete();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("div9600_n", wr_log.size(), 32'd2);
        check("div9600_lo", 32'(wr_log[0]), 32'({2'b10, 8'h8A}));
        check("div9600_hi", 32'(wr_log[1]), 32'({2'b11, 8'h02}));
        @(negedge clk);
        check("div9600_busy_clr", 32'(cfg_busy), 32'd0);

        // Single echo of 0x6D
        enable   = 1'b1;
        sif.tbr  = 1'b1;
        rd_count = 0;
        rx_q.push_back(8'h6D);
        for (int i = 0; i < 40 && tx_log.size() < 1; i++) @(negedge clk);
        @(negedge clk);
        check("echo1_n", tx_log.size(), 32'd1);
        check("echo1_data", 32'(tx_log[0]), 32'h6D);
        check("echo1_reads", rd_count, 32'd1);
        check("echo1_rx_cnt", 32'(rx_cnt), 32'd1);
        check("echo1_tx_cnt", 32'(tx_cnt), 32'd1);
        check("echo1_rd_to_wr", last_tx_cyc - last_rd_cyc, GUARD + 1);
        check("echo1_level", 32'(fifo_level), 32'd0);

        // Fill past DEPTH with tbr low, then drain
        sif.tbr  = 1'b0;
        rd_count = 0;
        for (int i = 0; i < 10; i++) rx_q.push_back(8'h10 + 8'(i));
        repeat (60) @(negedge clk);
        check("full_reads", rd_count, 32'd8);
        check("full_level", 32'(fifo_level), 32'd8);
        check("full_rda_held", 32'(sif.rda), 32'd1);
        check("full_spart_left", rx_q.size(), 32'd2);
        check("full_rx_cnt", 32'(rx_cnt), 32'd9);
        tx_log.delete();
        acc_seq.delete();
        min_gap = 1000;
        sif.tbr = 1'b1;
        for (int i = 0; i < 200 && tx_log.size() < 10; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("drain_n", tx_log.size(), 32'd10);
        for (int i = 0; i < 10; i++) check($sformatf("drain_byte%0d", i), 32'(tx_log[i]), 32'h10 + 32'(i));
        check("alt_0", 32'(acc_seq[0]), 32'd0);
        check("alt_1", 32'(acc_seq[1]), 32'd1);
        check("alt_2", 32'(acc_seq[2]), 32'd0);
        check("alt_3", 32'(acc_seq[3]), 32'd1);
        check("alt_4", 32'(acc_seq[4]), 32'd0);
        check("min_gap", min_gap, GUARD + 1);
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_tx_cnt", 32'(tx_cnt), 32'd11);

        // br_cfg 01 -> 11 with 3 bytes queued
        sif.tbr = 1'b0;
        rx_q.push_back(8'hC1);
        rx_q.push_back(8'hC2);
        rx_q.push_back(8'hC3);
        repeat (30) @(negedge clk);
        check("cfg_q_level", 32'(fifo_level), 32'd3);
        wr_log.delete();
        br_cfg = 2'b11;
        repeat (3) @(negedge clk);
        check("cfg_busy_set", 32'(cfg_busy), 32'd1);
        repeat (6) @(negedge clk);
        check("div38400_n", wr_log.size(), 32'd2);
        check("div38400_lo", 32'(wr_log[0]), 32'({2'b10, 8'hA1}));
        check("div38400_hi", 32'(wr_log[1]), 32'({2'b11, 8'h00}));
        check("cfg_busy_clr", 32'(cfg_busy), 32'd0);
        check("cfg_fifo_kept", 32'(fifo_level), 32'd3);
        tx_log.delete();
        sif.tbr = 1'b1;
        for (int i = 0; i < 60 && tx_log.size() < 3; i++) @(negedge clk);
        check("cfg_echo_n", tx_log.size(), 32'd3);
        check("cfg_echo0", 32'(tx_log[0]), 32'hC1);
        check("cfg_echo1", 32'(tx_log[1]), 32'hC2);
        check("cfg_echo2", 32'(tx_log[2]), 32'hC3);
        check("cfg_rx_cnt", 32'(rx_cnt), 32'd14);

        // Reset during WR_TX
        sif.tbr = 1'b0;
        rx_q.push_back(8'h55);
        rx_q.push_back(8'h66);
        repeat (20) @(negedge clk);
        check("rst_pre_level", 32'(fifo_level), 32'd2);
        sif.tbr = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (sif.iocs && !sif.iorw && sif.ioaddr == 2'b00) found = 1'b1;
        end
        check("rst_wrtx_seen", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_iocs", 32'(sif.iocs), 32'd0);
        check("rst_async_level", 32'(fifo_level), 32'd0);
        check("rst_async_tx_cnt", 32'(tx_cnt), 32'd0);
        repeat (3) @(negedge clk);
        wr_log.delete();
        tx_log.delete();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rerst_div_n", wr_log.size(), 32'd2);
        check("rerst_div_lo", 32'(wr_log[0]), 32'({2'b10, 8'hA1}));
        check("rerst_div_hi", 32'(wr_log[1]), 32'({2'b11, 8'h00}));
        check("rerst_rx_cnt", 32'(rx_cnt), 32'd0);
        repeat (10) @(negedge clk);
        check("empty_no_write", tx_log.size(), 32'd0);

        // enable low blocks the echo loop; raising it resumes
        enable   = 1'b0;
        rd_count = 0;
        rx_q.push_back(8'h77);
        repeat (20) @(negedge clk);
        check("dis_no_read", rd_count, 32'd0);
        check("dis_rda_held", 32'(sif.rda), 32'd1);
        enable = 1'b1;
        for (int i = 0; i < 40 && tx_log.size() < 1; i++) @(negedge clk);
        check("en_echo_n", tx_log.size(), 32'd1);
        check("en_echo_data", 32'(tx_log[0]), 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
